// File: rtl/track_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : synth_pkg
// Description : Shared widths, note constants and sequencer FSM encoding for
//               the two-track step sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int NOTE_W = 8;              // width of a stored note code
    localparam int STEP_W = 4;              // log2 of steps per track
    localparam int STEPS  = 2 ** STEP_W;    // steps per track
    localparam int ADDR_W = 1 + STEP_W;     // RAM address {track, step}

    // Note code 0 is a rest (silence).
    localparam logic [NOTE_W-1:0] REST = '0;

    // Shared RAM access FSM, explicitly 2-bit encoded.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        LATCH  = 2'd2
    } seq_state_e;

    // RAM address of a given step within a given track.
    function automatic logic [ADDR_W-1:0] make_addr(input logic             trk,
                                                    input logic [STEP_W-1:0] step);
        return {trk, step};
    endfunction

endpackage
`default_nettype wire

// File: rtl/track_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : track_sequencer_if
// Description : Record handshake and single-port note RAM bus of the track
//               sequencer.
//               rec_valid/rec_ready/rec_track/rec_note : live-record request
//               mem_addr/mem_we/mem_wdata/mem_rdata    : note RAM port
//               slave  : the sequencer side
//               master : the record source + RAM side
// Revision    : 1.0 - initial release
// ============================================================================
interface track_sequencer_if;

    logic                          rec_valid;
    logic                          rec_ready;
    logic                          rec_track;
    logic [synth_pkg::NOTE_W-1:0]  rec_note;

    logic [synth_pkg::ADDR_W-1:0]  mem_addr;
    logic                          mem_we;
    logic [synth_pkg::NOTE_W-1:0]  mem_wdata;
    logic [synth_pkg::NOTE_W-1:0]  mem_rdata;

    modport slave (
        input  rec_valid, rec_track, rec_note, mem_rdata,
        output rec_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output rec_valid, rec_track, rec_note, mem_rdata,
        input  rec_ready, mem_addr, mem_we, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/track_sequencer_step_counter.sv
`default_nettype none
// ============================================================================
// Module      : step_counter
// Description : Per-track step position. Wraps from 2**WIDTH-1 back to 0.
//               clk   : system clock
//               rst   : asynchronous active-high reset
//               clr   : synchronous clear (wins over inc)
//               inc   : advance one step
//               count : current step
// Revision    : 1.0 - initial release
// ============================================================================
module step_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Natural binary rollover gives the 2**WIDTH-1 -> 0 wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/track_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : track_sequencer
// Description : Steps two tracks through a shared single-port note RAM, one
//               step per tempo tick, and arbitrates the RAM between the two
//               track readers and one live-record writer.
//               clk, rst        : clock, asynchronous active-high reset
//               step_tick       : 1-cycle tempo pulse
//               tracks_playing  : bit t = track t playing
//               bus (slave)     : record handshake + note RAM port
//               note_out0/1     : current note of track 0/1 (held)
//               note_valid      : bit t pulses when note_out t updates
//               overrun         : pulse when a tick hits a still-pending read
// Revision    : 1.0 - initial release
// ============================================================================
module track_sequencer
    import synth_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               step_tick,
    input  logic [1:0]         tracks_playing,
    track_sequencer_if.slave   bus,
    output logic [NOTE_W-1:0]  note_out0,
    output logic [NOTE_W-1:0]  note_out1,
    output logic [1:0]         note_valid,
    output logic               overrun
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    seq_state_e          r_state;
    seq_state_e          w_state_nxt;

    logic [1:0]          r_rd_pend;
    logic                r_wr_pend;
    logic                r_rec_track;
    logic [NOTE_W-1:0]   r_rec_note;

    // Attributes of the access currently in ACCESS/LATCH.
    logic                r_acc_write;
    logic                r_acc_track;
    logic                r_acc_kill;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_we;
    logic [NOTE_W-1:0]   r_mem_wdata;

    logic [STEP_W-1:0]   w_step [2];
    logic [1:0]          w_step_inc;
    logic [1:0]          w_step_clr;

    logic [1:0]          w_rd_req;
    logic [1:0]          w_busy;
    logic [1:0]          w_tick_take;
    logic                w_rec_accept;

    logic                w_gnt_wr;
    logic [1:0]          w_gnt_rd;
    logic                w_latch_ok;
    logic [1:0]          w_latch_trk;

    // ------------------------------------------------------------------
    // Per-track step counters and request qualification
    // ------------------------------------------------------------------
    generate
        for (genvar t = 0; t < 2; t++) begin : g_trk
            step_counter #(
                .WIDTH (STEP_W)
            ) u_step (
                .clk   (clk),
                .rst   (rst),
                .clr   (w_step_clr[t]),
                .inc   (w_step_inc[t]),
                .count (w_step[t])
            );

            assign w_step_clr[t] = ~tracks_playing[t];
            assign w_step_inc[t] = w_latch_trk[t];

            // A read stays pending until its LATCH completes, not merely
            // until it is granted; a tick landing in that window is an
            // overrun and must not queue a second step.
            assign w_busy[t] = r_rd_pend[t]
                             | ((r_state != IDLE) & ~r_acc_write
                                & (r_acc_track == 1'(t)));

            assign w_rd_req[t]    = r_rd_pend[t] & tracks_playing[t];
            assign w_tick_take[t] = step_tick & tracks_playing[t] & ~w_busy[t];
        end
    endgenerate

    assign w_rec_accept  = bus.rec_valid & ~r_wr_pend;
    assign bus.rec_ready = ~r_wr_pend;

    assign w_latch_trk = w_latch_ok ? (r_acc_track ? 2'b10 : 2'b01) : 2'b00;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, grant and latch decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_wr    = 1'b0;
        w_gnt_rd    = 2'b00;
        w_latch_ok  = 1'b0;
        case (r_state)
            IDLE: begin
                // Writer first so a same-cycle record is visible to the reads.
                if (r_wr_pend) begin
                    w_gnt_wr    = 1'b1;
                    w_state_nxt = ACCESS;
                end else if (w_rd_req[0]) begin
                    w_gnt_rd    = 2'b01;
                    w_state_nxt = ACCESS;
                end else if (w_rd_req[1]) begin
                    w_gnt_rd    = 2'b10;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_state_nxt = r_acc_write ? IDLE : LATCH;
            end
            LATCH: begin
                // Drop the data if the track was stopped while in flight.
                w_latch_ok  = ~r_acc_kill & tracks_playing[r_acc_track];
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending flags and record capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend <= 2'b00;
        end else begin
            for (int t = 0; t < 2; t++) begin
                if (!tracks_playing[t]) begin
                    r_rd_pend[t] <= 1'b0;
                end else if (w_tick_take[t]) begin
                    r_rd_pend[t] <= 1'b1;
                end else if (w_gnt_rd[t]) begin
                    r_rd_pend[t] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_pend   <= 1'b0;
            r_rec_track <= 1'b0;
            r_rec_note  <= REST;
        end else if (w_rec_accept) begin
            r_wr_pend   <= 1'b1;
            r_rec_track <= bus.rec_track;
            r_rec_note  <= bus.rec_note;
        end else if (w_gnt_wr) begin
            r_wr_pend   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // RAM port registers and in-flight access bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_acc_write <= 1'b0;
            r_acc_track <= 1'b0;
            r_acc_kill  <= 1'b0;
        end else if (w_gnt_wr) begin
            // Write lands on the record track's current step; step is untouched.
            r_mem_addr  <= make_addr(r_rec_track, w_step[r_rec_track]);
            r_mem_we    <= 1'b1;
            r_mem_wdata <= r_rec_note;
            r_acc_write <= 1'b1;
            r_acc_track <= r_rec_track;
            r_acc_kill  <= 1'b0;
        end else if (w_gnt_rd != 2'b00) begin
            r_mem_addr  <= make_addr(w_gnt_rd[1], w_step[w_gnt_rd[1]]);
            r_mem_we    <= 1'b0;
            r_acc_write <= 1'b0;
            r_acc_track <= w_gnt_rd[1];
            r_acc_kill  <= 1'b0;
        end else begin
            if ((r_state == ACCESS) && r_acc_write) begin
                r_mem_we <= 1'b0;
            end
            if ((r_state != IDLE) && !r_acc_write && !tracks_playing[r_acc_track]) begin
                r_acc_kill <= 1'b1;
            end
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_wdata = r_mem_wdata;

    // ------------------------------------------------------------------
    // Voice outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_out0  <= REST;
            note_out1  <= REST;
            note_valid <= 2'b00;
            overrun    <= 1'b0;
        end else begin
            note_valid <= w_latch_trk;
            overrun    <= step_tick & (|(tracks_playing & w_busy));

            if (!tracks_playing[0]) begin
                note_out0 <= REST;
            end else if (w_latch_trk[0]) begin
                note_out0 <= bus.mem_rdata;
            end

            if (!tracks_playing[1]) begin
                note_out1 <= REST;
            end else if (w_latch_trk[1]) begin
                note_out1 <= bus.mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_track_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_track_sequencer
// Description : Self-checking bench for track_sequencer with a behavioural
//               single-port note RAM (read data one cycle after address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_track_sequencer;
    import synth_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_tick;
    logic [1:0]  tracks_playing;
    logic [7:0]  note_out0;
    logic [7:0]  note_out1;
    logic [1:0]  note_valid;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    track_sequencer_if bus ();

    track_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .step_tick      (step_tick),
        .tracks_playing (tracks_playing),
        .bus            (bus),
        .note_out0      (note_out0),
        .note_out1      (note_out1),
        .note_valid     (note_valid),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // Initial RAM image: 0x00 -> 0x3C, 0x10 -> 0x5A, everything else 0x80+addr.
    function automatic logic [7:0] ram_init(input int a);
        if (a == 0)  return 8'h3C;
        if (a == 16) return 8'h5A;
        return 8'(8'h80 + a);
    endfunction

    logic [7:0] ram [32];

    always @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 32; a++) ram[a] <= ram_init(a);
            bus.mem_rdata <= 8'h00;
        end else begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        logic [1:0] play;
        logic       tick;
        logic [4:0] addr;
        logic       we;
        logic [1:0] nv;
        logic [7:0] n0;
        logic [7:0] n1;
        logic       ovr;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        step_tick      = 1'b0;
        tracks_playing = 2'b00;
        bus.rec_valid  = 1'b0;
        bus.rec_track  = 1'b0;
        bus.rec_note   = 8'h00;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;

        // play tick | addr we nv n0 n1 ovr  (outputs one cycle after inputs)
        vecs[0]  = '{2'b01, 1'b1, 5'h00, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{2'b01, 1'b0, 5'h00, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{2'b01, 1'b0, 5'h00, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{2'b01, 1'b0, 5'h00, 1'b0, 2'b01, 8'h3C, 8'h00, 1'b0};
        vecs[4]  = '{2'b01, 1'b0, 5'h00, 1'b0, 2'b00, 8'h3C, 8'h00, 1'b0};
        vecs[5]  = '{2'b11, 1'b1, 5'h00, 1'b0, 2'b00, 8'h3C, 8'h00, 1'b0};
        vecs[6]  = '{2'b11, 1'b0, 5'h01, 1'b0, 2'b00, 8'h3C, 8'h00, 1'b0};
        vecs[7]  = '{2'b11, 1'b0, 5'h01, 1'b0, 2'b00, 8'h3C, 8'h00, 1'b0};
        vecs[8]  = '{2'b11, 1'b0, 5'h01, 1'b0, 2'b01, 8'h81, 8'h00, 1'b0};
        vecs[9]  = '{2'b11, 1'b0, 5'h10, 1'b0, 2'b00, 8'h81, 8'h00, 1'b0};
        vecs[10] = '{2'b11, 1'b0, 5'h10, 1'b0, 2'b00, 8'h81, 8'h00, 1'b0};
        vecs[11] = '{2'b11, 1'b0, 5'h10, 1'b0, 2'b10, 8'h81, 8'h5A, 1'b0};
        vecs[12] = '{2'b11, 1'b0, 5'h10, 1'b0, 2'b00, 8'h81, 8'h5A, 1'b0};
        vecs[13] = '{2'b01, 1'b1, 5'h10, 1'b0, 2'b00, 8'h81, 8'h00, 1'b0};
        vecs[14] = '{2'b01, 1'b0, 5'h02, 1'b0, 2'b00, 8'h81, 8'h00, 1'b0};
        vecs[15] = '{2'b01, 1'b1, 5'h02, 1'b0, 2'b00, 8'h81, 8'h00, 1'b1};
        vecs[16] = '{2'b01, 1'b0, 5'h02, 1'b0, 2'b01, 8'h82, 8'h00, 1'b0};
        vecs[17] = '{2'b01, 1'b0, 5'h02, 1'b0, 2'b00, 8'h82, 8'h00, 1'b0};
        vecs[18] = '{2'b01, 1'b0, 5'h02, 1'b0, 2'b00, 8'h82, 8'h00, 1'b0};
        vecs[19] = '{2'b01, 1'b1, 5'h02, 1'b0, 2'b00, 8'h82, 8'h00, 1'b0};
        vecs[20] = '{2'b01, 1'b0, 5'h03, 1'b0, 2'b00, 8'h82, 8'h00, 1'b0};
        vecs[21] = '{2'b01, 1'b0, 5'h03, 1'b0, 2'b00, 8'h82, 8'h00, 1'b0};
        vecs[22] = '{2'b01, 1'b0, 5'h03, 1'b0, 2'b01, 8'h83, 8'h00, 1'b0};

        // ---------------- reset state ----------------
        rst            = 1'b1;
        step_tick      = 1'b0;
        tracks_playing = 2'b00;
        bus.rec_valid  = 1'b0;
        bus.rec_track  = 1'b0;
        bus.rec_note   = 8'h00;
        repeat (2) cyc();
        check("rst.mem_addr",   32'(bus.mem_addr),  32'h00);
        check("rst.mem_we",     32'(bus.mem_we),    32'h0);
        check("rst.mem_wdata",  32'(bus.mem_wdata), 32'h00);
        check("rst.rec_ready",  32'(bus.rec_ready), 32'h1);
        check("rst.note_valid", 32'(note_valid),    32'h0);
        check("rst.notes",      32'({note_out1, note_out0}), 32'h0);
        check("rst.overrun",    32'(overrun),       32'h0);
        rst = 1'b0;

        // ---------------- table: single read, dual read, overrun ----------------
        for (int i = 0; i < 23; i++) begin
            tracks_playing = vecs[i].play;
            step_tick      = vecs[i].tick;
            cyc();
            check($sformatf("vec%0d.mem_addr", i),   32'(bus.mem_addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d.mem_we", i),     32'(bus.mem_we),   32'(vecs[i].we));
            check($sformatf("vec%0d.note_valid", i), 32'(note_valid),   32'(vecs[i].nv));
            check($sformatf("vec%0d.note_out0", i),  32'(note_out0),    32'(vecs[i].n0));
            check($sformatf("vec%0d.note_out1", i),  32'(note_out1),    32'(vecs[i].n1));
            check($sformatf("vec%0d.overrun", i),    32'(overrun),      32'(vecs[i].ovr));
        end
        step_tick = 1'b0;

        // ---------------- 17 ticks: address walk and wrap ----------------
        do_reset();
        tracks_playing = 2'b01;
        for (int i = 0; i < 17; i++) begin
            step_tick = 1'b1;
            cyc();
            step_tick = 1'b0;
            cyc();
            check($sformatf("wrap%0d.mem_addr", i), 32'(bus.mem_addr), 32'(i % 16));
            cyc();
            cyc();
            check($sformatf("wrap%0d.note_valid", i), 32'(note_valid), 32'h1);
            check($sformatf("wrap%0d.note_out0", i),  32'(note_out0),  32'(ram_init(i % 16)));
            cyc();
            cyc();
        end

        // ---------------- record + tick on track 1 ----------------
        tracks_playing = 2'b10;
        cyc();
        cyc();
        step_tick     = 1'b1;
        bus.rec_valid = 1'b1;
        bus.rec_track = 1'b1;
        bus.rec_note  = 8'h45;
        check("rec.ready_before", 32'(bus.rec_ready), 32'h1);
        cyc();
        step_tick     = 1'b0;
        bus.rec_valid = 1'b0;
        check("rec.ready_low", 32'(bus.rec_ready), 32'h0);
        cyc();
        check("rec.we",        32'(bus.mem_we),    32'h1);
        check("rec.addr",      32'(bus.mem_addr),  32'h10);
        check("rec.wdata",     32'(bus.mem_wdata), 32'h45);
        check("rec.ready_back", 32'(bus.rec_ready), 32'h1);
        cyc();
        check("rec.we_drop",   32'(bus.mem_we),    32'h0);
        cyc();
        check("rec.read_addr", 32'(bus.mem_addr),  32'h10);
        check("rec.read_we",   32'(bus.mem_we),    32'h0);
        cyc();
        cyc();
        check("rec.note_valid", 32'(note_valid), 32'h2);
        check("rec.note_out1",  32'(note_out1),  32'h45);
        cyc();
        check("rec.nv_pulse",   32'(note_valid), 32'h0);

        // ---------------- reset during a write ACCESS ----------------
        bus.rec_valid = 1'b1;
        bus.rec_track = 1'b1;
        bus.rec_note  = 8'h77;
        cyc();
        bus.rec_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.mem_we) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        check("arst.we_seen",    32'(found),        32'h1);
        check("arst.write_addr", 32'(bus.mem_addr), 32'h11);
        rst = 1'b1;
        #1;
        check("arst.mem_we",     32'(bus.mem_we),    32'h0);
        check("arst.mem_addr",   32'(bus.mem_addr),  32'h00);
        check("arst.mem_wdata",  32'(bus.mem_wdata), 32'h00);
        check("arst.rec_ready",  32'(bus.rec_ready), 32'h1);
        check("arst.note_out1",  32'(note_out1),     32'h00);
        check("arst.note_valid", 32'(note_valid),    32'h0);
        #1;
        rst            = 1'b0;
        tracks_playing = 2'b00;
        cyc();

        // ---------------- stop a track mid-read ----------------
        tracks_playing = 2'b01;
        step_tick      = 1'b1;
        cyc();
        step_tick = 1'b0;
        cyc();
        cyc();
        cyc();
        check("stop.first_nv",   32'(note_valid), 32'h1);
        check("stop.first_note", 32'(note_out0),  32'h3C);
        cyc();
        cyc();
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
        cyc();
        check("stop.read_addr", 32'(bus.mem_addr), 32'h01);
        tracks_playing = 2'b00;
        cyc();
        check("stop.note_out0", 32'(note_out0),  32'h00);
        check("stop.nv_latch",  32'(note_valid), 32'h0);
        cyc();
        check("stop.nv_after",  32'(note_valid), 32'h0);
        check("stop.note_hold", 32'(note_out0),  32'h00);
        cyc();
        tracks_playing = 2'b01;
        step_tick      = 1'b1;
        cyc();
        step_tick = 1'b0;
        cyc();
        check("stop.step_cleared", 32'(bus.mem_addr), 32'h00);
        cyc();
        cyc();
        check("stop.replay_nv",   32'(note_valid), 32'h1);
        check("stop.replay_note", 32'(note_out0),  32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
